regfile_wb_scheduler: RTL

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wb_scheduler_if.sv | 16 +
 rtl/regfile_wb_scheduler_rr_arbiter2.sv | 30 +++
 rtl/regfile_wb_scheduler.sv | 86 ++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing, register-address type and writeback-source encoding for the
// register-file writeback scheduler.
package regfile_pkg;
  localparam int REG_COUNT  = 32;
  localparam int REG_WIDTH  = 32;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LOAD = 1'b1
  } wb_src_e;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback handshake bundle: two sources (ALU, load) each offering addr/data
// under valid, with a per-source ready returned by the scheduler.
interface regfile_wb_scheduler_if
  import regfile_pkg::*;
#(
  parameter int AW = REG_ADDR_W,
  parameter int DW = REG_WIDTH
);
  logic [1:0]         wb_valid_i;
  logic [1:0][AW-1:0] wb_addr_i;
  logic [1:0][DW-1:0] wb_data_i;
  logic [1:0]         wb_ready_o;

  modport master (output wb_valid_i, output wb_addr_i, output wb_data_i, input wb_ready_o);
  modport slave  (input wb_valid_i, input wb_addr_i, input wb_data_i, output wb_ready_o);
endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter with a combinational one-hot grant; the
// pointer remembers the last granted requester and moves only on a grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  logic last;

  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Reset points at requester 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst)
      last <= 1'b1;
    else if (grant != 2'b00)
      last <= grant[1];
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Scoreboard plus writeback port scheduler: tracks pending destinations, stalls
// issue on hazards and funnels two writeback sources onto one register-file port.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int REG_COUNT = regfile_pkg::REG_COUNT,
  parameter int REG_WIDTH = regfile_pkg::REG_WIDTH,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid_i,
  input  logic [AW-1:0]                 alloc_addr_i,
  input  logic [AW-1:0]                 rs1_addr_i,
  input  logic [AW-1:0]                 rs2_addr_i,
  output logic                          stall_o,
  regfile_wb_scheduler_if.slave         wb,
  output logic                          reg_wr_en_o,
  output logic [AW-1:0]                 wr_addr_o,
  output logic [REG_WIDTH-1:0]          wr_data_o
);
  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_nxt;
  logic [1:0]           grant;
  logic                 alloc_fire;
  wb_src_e              sel;

  logic                 wr_en_p1;
  logic [AW-1:0]        wr_addr_p1;
  logic [REG_WIDTH-1:0] wr_data_p1;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (wb.wb_valid_i),
    .grant (grant)
  );

  assign wb.wb_ready_o = grant;
  assign sel           = grant[1] ? SRC_LOAD : SRC_ALU;

  always_comb begin
    stall_o = 1'b0;
    if (!rst)
      stall_o = busy[rs1_addr_i] | busy[rs2_addr_i] | (alloc_valid_i & busy[alloc_addr_i]);
  end

  assign alloc_fire = alloc_valid_i & ~stall_o & (alloc_addr_i != '0);

  // Allocation is applied after the clear so a same-edge allocate wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_en_p1)
      busy_nxt[wr_addr_p1] = 1'b0;
    if (alloc_fire)
      busy_nxt[alloc_addr_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  // Stage p1: granted transfer becomes the register-file write; x0 is dropped
  // and the address/data hold their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else if (grant != 2'b00 && wb.wb_addr_i[sel] != '0) begin
      wr_en_p1   <= 1'b1;
      wr_addr_p1 <= wb.wb_addr_i[sel];
      wr_data_p1 <= wb.wb_data_i[sel];
    end else begin
      wr_en_p1   <= 1'b0;
    end
  end

  assign reg_wr_en_o = wr_en_p1;
  assign wr_addr_o   = wr_addr_p1;
  assign wr_data_o   = wr_data_p1;
endmodule
